// File: rtl/alu_sequencer.sv
// Sequences one request at a time through the external 16-bit ALU: latch, setup, two enable cycles, capture.
// Result appears 3 edges after acceptance; req_ready is low while an operation is in flight.
module alu_sequencer #(
  parameter int WIDTH  = 16,
  parameter int MAX_OP = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_use_carry,
  input  logic             clear_carry,
  output logic [WIDTH-1:0] alu_in_1,
  output logic [WIDTH-1:0] alu_in_2,
  output logic [3:0]       alu_select,
  output logic             alu_carry_in,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_carry_out,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             op_error,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETUP, EXEC, CAPT} state_t;

  localparam logic [3:0] MAX_OP_L = 4'(MAX_OP);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             csel_q, csel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             rv_q, rv_d;
  logic             err_q, err_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    csel_d     = csel_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = clear_carry ? 1'b0 : carry_q;
    rv_d       = 1'b0;
    err_d      = 1'b0;
    req_ready  = 1'b0;
    busy       = 1'b1;
    alu_enable = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          // Uses the flag as it stands now, before any clear or capture on this edge.
          csel_d  = req_use_carry & carry_q;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (op_q > MAX_OP_L) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_enable = 1'b1;
        state_d    = CAPT;
      end
      CAPT: begin
        alu_enable = 1'b1;
        result_d   = alu_data;
        carry_d    = alu_carry_out;
        zero_d     = alu_zero;
        rv_d       = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      csel_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      csel_q   <= csel_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
    end
  end

  // Operand latches double as the ALU drive lines, so they only move on entry to SETUP.
  assign alu_in_1     = a_q;
  assign alu_in_2     = b_q;
  assign alu_select   = op_q;
  assign alu_carry_in = csel_q;
  assign result       = result_q;
  assign carry_flag   = carry_q;
  assign zero_flag    = zero_q;
  assign result_valid = rv_q;
  assign op_error     = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an age-since-acceptance reference model and a behavioural ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        req_use_carry, clear_carry;
  logic [15:0] alu_in_1, alu_in_2;
  logic [3:0]  alu_select;
  logic        alu_carry_in, alu_enable;
  logic [15:0] alu_data;
  logic        alu_carry_out, alu_zero;
  logic [15:0] result;
  logic        result_valid, carry_flag, zero_flag, op_error, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(16), .MAX_OP(7)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_use_carry(req_use_carry),
    .clear_carry(clear_carry), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_select(alu_select), .alu_carry_in(alu_carry_in), .alu_enable(alu_enable),
    .alu_data(alu_data), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero),
    .result(result), .result_valid(result_valid), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .op_error(op_error), .busy(busy)
  );

  // {carry, result} of the 17-bit ALU operation
  function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    logic [16:0] r;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, ~a};
      4'd6:    r = {1'b0, a} + 17'd1;
      4'd7:    r = {1'b0, a} - 17'd1;
      default: r = 17'd0;
    endcase
    return r;
  endfunction

  // Behavioural ALU; garbage on the bus while disabled exposes mistimed sampling.
  assign {alu_carry_out, alu_data} = alu_enable ? alu_f(alu_select, alu_in_1, alu_in_2, alu_carry_in)
                                                : 17'h1DEAD;
  assign alu_zero = alu_enable ? (alu_data == 16'h0000) : 1'b1;

  // Reference model: age = edges since acceptance (99 = nothing in flight)
  int          age = 99;
  logic        m_legal = 1'b1;
  logic [3:0]  m_op = '0;
  logic [15:0] m_a = '0, m_b = '0, m_res = '0;
  logic        m_cin = 1'b0, m_c = 1'b0, m_z = 1'b0;
  logic [16:0] m_exp = '0;

  function automatic logic m_busy();
    return m_legal ? (age <= 2) : (age <= 0);
  endfunction

  always @(posedge clk) begin
    logic acc;
    logic ncin;
    if (reset) begin
      age = 99; m_legal = 1'b1; m_op = '0; m_a = '0; m_b = '0;
      m_cin = 1'b0; m_res = '0; m_c = 1'b0; m_z = 1'b0;
    end else begin
      acc  = req_valid && !m_busy();
      ncin = req_use_carry & m_c;
      if (m_legal && age == 2) begin
        m_res = m_exp[15:0];
        m_c   = m_exp[16];
        m_z   = (m_exp[15:0] == 16'h0000);
      end else if (clear_carry) begin
        m_c = 1'b0;
      end
      if (acc) begin
        m_op = req_op; m_a = req_a; m_b = req_b; m_cin = ncin;
        m_legal = (req_op <= 4'd7);
        m_exp = alu_f(req_op, req_a, req_b, ncin);
        age = 0;
      end else if (age < 99) begin
        age = age + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",    32'(req_ready),    32'(!m_busy()));
      chk("busy",         32'(busy),         32'(m_busy()));
      chk("alu_enable",   32'(alu_enable),   32'(m_legal && (age == 1 || age == 2)));
      chk("result_valid", 32'(result_valid), 32'(m_legal && age == 3));
      chk("op_error",     32'(op_error),     32'(!m_legal && age == 1));
      chk("alu_in_1",     32'(alu_in_1),     32'(m_a));
      chk("alu_in_2",     32'(alu_in_2),     32'(m_b));
      chk("alu_select",   32'(alu_select),   32'(m_op));
      chk("alu_carry_in", 32'(alu_carry_in), 32'(m_cin));
      chk("result",       32'(result),       32'(m_res));
      chk("carry_flag",   32'(carry_flag),   32'(m_c));
      chk("zero_flag",    32'(zero_flag),    32'(m_z));
    end
  end

  // Event counters sampled on the active edge so the stimulus can clear them at negedge race-free.
  int en_cnt = 0, rv_cnt = 0, err_cnt = 0, ecnt = 0;
  int acc_q[$];
  always @(posedge clk) begin
    ecnt++;
    if (alu_enable)   en_cnt++;
    if (result_valid) rv_cnt++;
    if (op_error)     err_cnt++;
    if (req_valid && req_ready && !reset) acc_q.push_back(ecnt);
  end

  // Presents a request and returns at the negedge after the model's acceptance edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic uc);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_use_carry = uc;
    for (int i = 0; i < 20; i++) begin
      if (!m_busy()) break;
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_use_carry = 1'b0; clear_carry = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_ready",  32'(req_ready), 32'h1);
    chk("rst_enable", 32'(alu_enable), 32'h0);

    // ADD with wrap to zero
    en_cnt = 0;
    send(4'd0, 16'hFFFF, 16'h0001, 1'b0);
    repeat (3) @(negedge clk);
    chk("add1_result", 32'(result), 32'h0000);
    chk("add1_carry",  32'(carry_flag), 32'h1);
    chk("add1_zero",   32'(zero_flag), 32'h1);
    chk("add1_rv",     32'(result_valid), 32'h1);
    chk("add1_en_cycles", 32'(en_cnt), 32'd2);

    // ADD with carry, accepted in the result_valid cycle
    send(4'd0, 16'h0001, 16'h0001, 1'b1);
    chk("adc_cin", 32'(alu_carry_in), 32'h1);
    repeat (3) @(negedge clk);
    chk("adc_result", 32'(result), 32'h0003);
    chk("adc_carry",  32'(carry_flag), 32'h0);
    chk("adc_zero",   32'(zero_flag), 32'h0);

    send(4'd1, 16'h0005, 16'h0007, 1'b0);
    repeat (3) @(negedge clk);
    chk("sub_result", 32'(result), 32'hFFFE);
    chk("sub_carry",  32'(carry_flag), 32'h1);
    chk("sub_zero",   32'(zero_flag), 32'h0);

    // Illegal opcode
    @(negedge clk);
    en_cnt = 0; rv_cnt = 0; err_cnt = 0;
    send(4'd9, 16'h1234, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("ill_err_pulses", 32'(err_cnt), 32'd1);
    chk("ill_en_cycles",  32'(en_cnt), 32'd0);
    chk("ill_rv",         32'(rv_cnt), 32'd0);
    chk("ill_result",     32'(result), 32'hFFFE);
    chk("ill_carry",      32'(carry_flag), 32'h1);
    chk("ill_zero",       32'(zero_flag), 32'h0);

    send(4'd5, 16'hFFFF, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("not_result", 32'(result), 32'h0000);
    chk("not_zero",   32'(zero_flag), 32'h1);

    // Three XORs back to back with req_valid held high
    acc_q.delete();
    send(4'd4, 16'hA5A5, 16'h0FF0, 1'b0);
    send(4'd4, 16'h1234, 16'h4321, 1'b0);
    send(4'd4, 16'hBEEF, 16'hBEEF, 1'b0);
    repeat (3) @(negedge clk);
    chk("xor_result", 32'(result), 32'h0000);
    chk("xor_zero",   32'(zero_flag), 32'h1);
    chk("xor_accepts", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      chk("xor_gap1", 32'(acc_q[1] - acc_q[0]), 32'd4);
      chk("xor_gap2", 32'(acc_q[2] - acc_q[1]), 32'd4);
    end

    // clear_carry on the capture edge: capture wins
    send(4'd0, 16'hFFFF, 16'h0002, 1'b0);
    repeat (2) @(negedge clk);
    clear_carry = 1'b1;
    @(negedge clk);
    clear_carry = 1'b0;
    chk("clrcapt_carry",  32'(carry_flag), 32'h1);
    chk("clrcapt_result", 32'(result), 32'h0001);

    // clear_carry on the acceptance edge: carry_sel sees the pre-clear flag
    clear_carry = 1'b1;
    send(4'd0, 16'h0001, 16'h0001, 1'b1);
    clear_carry = 1'b0;
    chk("clracc_cin",   32'(alu_carry_in), 32'h1);
    chk("clracc_carry", 32'(carry_flag), 32'h0);
    repeat (3) @(negedge clk);
    chk("clracc_result", 32'(result), 32'h0003);

    // Reset during EXEC
    send(4'd6, 16'h00FF, 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstx_enable", 32'(alu_enable), 32'h0);
    chk("rstx_busy",   32'(busy), 32'h0);
    chk("rstx_result", 32'(result), 32'h0);
    chk("rstx_carry",  32'(carry_flag), 32'h0);
    chk("rstx_zero",   32'(zero_flag), 32'h0);
    rv_cnt = 0; err_cnt = 0;
    repeat (4) @(negedge clk);
    chk("rstx_no_rv",  32'(rv_cnt), 32'd0);
    chk("rstx_no_err", 32'(err_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
